// File: rtl/audio_regs_gen2.sv
// Second-generation control/status register file for the TDM/packet audio path:
// RX/TX control, payload capture, saturating counters, W1C status, gain shadow/commit and irq.
module audio_regs_gen2 #(
    parameter int NCH = 4,
    parameter int PW  = 256,
    parameter int CW  = 16,
    parameter int AW  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val,
    input  logic [AW-1:0]     addr,
    input  logic              write,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              rx_en,
    output logic [7:0]        rx_clk_mask,
    output logic [7:0]        rx_clk_patt,
    input  logic              rx_sample,
    input  logic              rx_valid,
    input  logic [PW-1:0]     rx_pdata,
    output logic              tx_en,
    input  logic              tx_retrans_incr,
    input  logic              tx_drop_incr,
    output logic              tx_valid,
    output logic [PW-1:0]     tx_pdata,
    output logic [8*NCH-1:0]  gain,
    output logic [8*NCH-1:0]  bal,
    output logic              sel,
    output logic              irq
);

    localparam int NW = PW / 32;
    localparam logic [CW-1:0] CMAX = '1;

    localparam logic [AW-1:0] A_RX_CTRL = AW'('h000);
    localparam logic [AW-1:0] A_STAT    = AW'('h004);
    localparam logic [AW-1:0] A_RX_SCNT = AW'('h008);
    localparam logic [AW-1:0] A_IRQ_EN  = AW'('h00C);
    localparam logic [AW-1:0] A_RX_PD   = AW'('h010);
    localparam logic [AW-1:0] A_TX_CTRL = AW'('h100);
    localparam logic [AW-1:0] A_TX_CNT  = AW'('h104);
    localparam logic [AW-1:0] A_TX_GO   = AW'('h108);
    localparam logic [AW-1:0] A_TX_PD   = AW'('h110);
    localparam logic [AW-1:0] A_GAIN    = AW'('h200);
    localparam logic [AW-1:0] A_COMMIT  = AW'('h2FC);
    localparam logic [AW-1:0] A_SEL     = AW'('h300);

    // Bus handshake: every cycle with val=1 is one access; the following cycle
    // ready=1 and rdata carries the read value (or the write data echo). val=0 gives ready=0, rdata=0.

    logic [AW-1:0]    a;
    logic             unused_addr_lsb;
    logic [3:0]       stat;
    logic [3:0]       irq_en;
    logic [CW-1:0]    scnt;
    logic [CW-1:0]    retr;
    logic [CW-1:0]    drop;
    logic [PW-1:0]    cap;
    logic [8*NCH-1:0] gain_sh;
    logic [8*NCH-1:0] bal_sh;
    logic             dirty;
    logic [31:0]      rd_val;

    assign a = {addr[AW-1:2], 2'b00};
    assign unused_addr_lsb = ^addr[1:0];

    logic wr, wr_rxctrl, wr_stat, wr_scnt, wr_irqen, wr_txctrl, wr_txcnt, wr_txgo;
    logic wr_commit, wr_sel, wr_gsh;

    assign wr        = val & write;
    assign wr_rxctrl = wr && (a == A_RX_CTRL);
    assign wr_stat   = wr && (a == A_STAT);
    assign wr_scnt   = wr && (a == A_RX_SCNT);
    assign wr_irqen  = wr && (a == A_IRQ_EN);
    assign wr_txctrl = wr && (a == A_TX_CTRL);
    assign wr_txcnt  = wr && (a == A_TX_CNT);
    assign wr_txgo   = wr && (a == A_TX_GO);
    assign wr_commit = wr && (a == A_COMMIT);
    assign wr_sel    = wr && (a == A_SEL);

    always_comb begin
        wr_gsh = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (wr && (a == A_GAIN + AW'(4 * c))) wr_gsh = 1'b1;
        end
    end

    // Event qualification: capture only while enabled, hold the buffer while unread.
    logic samp_inc, cap_load, cap_ovf, samp_sat, tx_sat;
    logic [3:0] stat_set, stat_clr;

    assign samp_inc = rx_sample & rx_en;
    assign cap_load = rx_valid & rx_en & ~stat[0];
    assign cap_ovf  = rx_valid & rx_en & stat[0];
    assign samp_sat = samp_inc && (scnt == CMAX);
    assign tx_sat   = (tx_retrans_incr && (retr == CMAX)) || (tx_drop_incr && (drop == CMAX));
    assign stat_set = {tx_sat, samp_sat, cap_ovf, cap_load};
    assign stat_clr = wr_stat ? wdata[3:0] : 4'd0;

    always_comb begin
        rd_val = 32'hBADACE55;
        if (a == A_RX_CTRL) rd_val = {rx_en, 15'd0, rx_clk_mask, rx_clk_patt};
        if (a == A_STAT)    rd_val = {28'd0, stat};
        if (a == A_RX_SCNT) rd_val = 32'(scnt);
        if (a == A_IRQ_EN)  rd_val = {28'd0, irq_en};
        if (a == A_TX_CTRL) rd_val = {tx_en, 31'd0};
        if (a == A_TX_CNT)  rd_val = {16'(retr), 16'(drop)};
        if (a == A_TX_GO)   rd_val = 32'd0;
        if (a == A_COMMIT)  rd_val = {31'd0, dirty};
        if (a == A_SEL)     rd_val = {31'd0, sel};
        for (int k = 0; k < NW; k++) begin
            if (a == A_RX_PD + AW'(4 * k)) rd_val = cap[32*k +: 32];
            if (a == A_TX_PD + AW'(4 * k)) rd_val = tx_pdata[32*k +: 32];
        end
        for (int c = 0; c < NCH; c++) begin
            if (a == A_GAIN + AW'(4 * c)) rd_val = {16'd0, bal_sh[8*c +: 8], gain_sh[8*c +: 8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready       <= 1'b0;
            rdata       <= 32'd0;
            rx_en       <= 1'b0;
            rx_clk_mask <= 8'd0;
            rx_clk_patt <= 8'd0;
            stat        <= 4'd0;
            irq_en      <= 4'd0;
            scnt        <= '0;
            retr        <= '0;
            drop        <= '0;
            cap         <= '0;
            tx_en       <= 1'b0;
            tx_valid    <= 1'b0;
            tx_pdata    <= '0;
            gain_sh     <= '0;
            bal_sh      <= '0;
            gain        <= '0;
            bal         <= '0;
            dirty       <= 1'b0;
            sel         <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ready <= val;
            rdata <= val ? (write ? wdata : rd_val) : 32'd0;

            if (wr_rxctrl) begin
                rx_en       <= wdata[31];
                rx_clk_mask <= wdata[15:8];
                rx_clk_patt <= wdata[7:0];
            end
            // A set event on the same edge as a W1C wins.
            stat <= (stat & ~stat_clr) | stat_set;
            if (wr_irqen) irq_en <= wdata[3:0];
            if (cap_load) cap <= rx_pdata;

            // Counter writes take priority over a coincident increment.
            if (wr_scnt) scnt <= wdata[CW-1:0];
            else if (samp_inc && (scnt != CMAX)) scnt <= scnt + CW'(1);

            if (wr_txcnt) begin
                retr <= wdata[16 +: CW];
                drop <= wdata[CW-1:0];
            end else begin
                if (tx_retrans_incr && (retr != CMAX)) retr <= retr + CW'(1);
                if (tx_drop_incr && (drop != CMAX)) drop <= drop + CW'(1);
            end

            if (wr_txctrl) tx_en <= wdata[31];
            tx_valid <= wr_txgo & wdata[0] & tx_en;
            for (int k = 0; k < NW; k++) begin
                if (wr && (a == A_TX_PD + AW'(4 * k))) tx_pdata[32*k +: 32] <= wdata;
            end

            for (int c = 0; c < NCH; c++) begin
                if (wr && (a == A_GAIN + AW'(4 * c))) begin
                    gain_sh[8*c +: 8] <= wdata[7:0];
                    bal_sh[8*c +: 8]  <= wdata[15:8];
                end
            end
            // Commit publishes all shadows atomically.
            if (wr_gsh) begin
                dirty <= 1'b1;
            end else if (wr_commit && wdata[0]) begin
                gain  <= gain_sh;
                bal   <= bal_sh;
                dirty <= 1'b0;
            end

            if (wr_sel) sel <= wdata[0];
            irq <= |(stat & irq_en);
        end
    end

endmodule

// File: tb/tb_audio_regs_gen2.sv
// Self-checking bench for audio_regs_gen2: register table, multi-cycle corner
// sequences, then randomized counter/status traffic against an arithmetic model.
module tb_audio_regs_gen2;

    localparam int NCH = 4;
    localparam int PW  = 128;
    localparam int CW  = 4;
    localparam int AW  = 10;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              val;
    logic [AW-1:0]     addr;
    logic              write;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              rx_en;
    logic [7:0]        rx_clk_mask;
    logic [7:0]        rx_clk_patt;
    logic              rx_sample;
    logic              rx_valid;
    logic [PW-1:0]     rx_pdata;
    logic              tx_en;
    logic              tx_retrans_incr;
    logic              tx_drop_incr;
    logic              tx_valid;
    logic [PW-1:0]     tx_pdata;
    logic [8*NCH-1:0]  gain;
    logic [8*NCH-1:0]  bal;
    logic              sel;
    logic              irq;

    int checks = 0;
    int failures = 0;

    audio_regs_gen2 #(.NCH(NCH), .PW(PW), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .val(val), .addr(addr), .write(write), .wdata(wdata),
        .rdata(rdata), .ready(ready), .rx_en(rx_en), .rx_clk_mask(rx_clk_mask),
        .rx_clk_patt(rx_clk_patt), .rx_sample(rx_sample), .rx_valid(rx_valid),
        .rx_pdata(rx_pdata), .tx_en(tx_en), .tx_retrans_incr(tx_retrans_incr),
        .tx_drop_incr(tx_drop_incr), .tx_valid(tx_valid), .tx_pdata(tx_pdata),
        .gain(gain), .bal(bal), .sel(sel), .irq(irq)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          wr;
        logic [9:0]  ad;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wr, logic [9:0] ad, logic [31:0] wd, logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.ad = ad; v.wd = wd; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Driver: one bus access; returns at posedge+1 of the acknowledging cycle.
    task automatic bus(input bit wr, input logic [9:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(negedge clk);
        val = 1'b1; write = wr; addr = ad; wdata = wd;
        @(posedge clk);
        #1;
        check("ready", {31'd0, ready}, 32'd1);
        rd = rdata;
        val = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sample();
        rx_sample = 1'b1; step(); rx_sample = 1'b0;
    endtask

    task automatic pulse_valid(input logic [PW-1:0] p);
        rx_valid = 1'b1; rx_pdata = p; step(); rx_valid = 1'b0;
    endtask

    logic [31:0]   rd;
    logic [PW-1:0] pat_p, pat_q;

    // Reference model state
    int   m_scnt, m_retr, m_drop;
    logic [3:0] m_stat, m_en;

    initial begin
        rst = 1'b1; val = 1'b0; addr = '0; write = 1'b0; wdata = '0;
        rx_sample = 1'b0; rx_valid = 1'b0; rx_pdata = '0;
        tx_retrans_incr = 1'b0; tx_drop_incr = 1'b0;
        repeat (3) step();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rxctl", {7'd0, rx_en, 8'd0, rx_clk_mask, rx_clk_patt}, 32'd0);
        check("rst_txout", {29'd0, tx_en, tx_valid, |tx_pdata}, 32'd0);
        check("rst_gain", gain, 32'd0);
        check("rst_bal", bal, 32'd0);
        check("rst_sel_irq", {30'd0, sel, irq}, 32'd0);
        rst = 1'b0;

        // Register table
        tbl.push_back(mk(0, 10'h000, 0, 32'h0));
        tbl.push_back(mk(0, 10'h2FC, 0, 32'h0));
        tbl.push_back(mk(0, 10'h3F0, 0, 32'hBADACE55));
        tbl.push_back(mk(0, 10'h004, 0, 32'h0));
        tbl.push_back(mk(0, 10'h104, 0, 32'h0));
        tbl.push_back(mk(1, 10'h000, 32'h8000A55A, 32'h8000A55A));
        tbl.push_back(mk(0, 10'h000, 0, 32'h8000A55A));
        tbl.push_back(mk(0, 10'h003, 0, 32'h8000A55A));
        tbl.push_back(mk(1, 10'h00C, 32'h4, 32'h4));
        tbl.push_back(mk(0, 10'h00C, 0, 32'h4));
        tbl.push_back(mk(1, 10'h300, 32'h1, 32'h1));
        tbl.push_back(mk(0, 10'h300, 0, 32'h1));
        tbl.push_back(mk(0, 10'h108, 0, 32'h0));
        tbl.push_back(mk(0, 10'h020, 0, 32'hBADACE55));
        tbl.push_back(mk(0, 10'h120, 0, 32'hBADACE55));
        tbl.push_back(mk(0, 10'h210, 0, 32'hBADACE55));
        tbl.push_back(mk(1, 10'h3F0, 32'h12345678, 32'h12345678));
        tbl.push_back(mk(0, 10'h3F0, 0, 32'hBADACE55));
        tbl.push_back(mk(1, 10'h110, 32'hDEADBEEF, 32'hDEADBEEF));
        tbl.push_back(mk(1, 10'h11C, 32'hCAFEF00D, 32'hCAFEF00D));
        tbl.push_back(mk(0, 10'h110, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 10'h11C, 0, 32'hCAFEF00D));
        foreach (tbl[i]) begin
            bus(tbl[i].wr, tbl[i].ad, tbl[i].wd, rd);
            check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        step();
        check("idle_ready_rdata", {ready, rdata[30:0]}, 32'd0);
        check("rx_ctrl_out", {15'd0, rx_en, rx_clk_mask, rx_clk_patt}, 32'h0001A55A);
        check("sel_out", {31'd0, sel}, 32'd1);

        // Capture and overflow
        pat_p = {$urandom, $urandom, $urandom, $urandom};
        pat_q = ~pat_p;
        pulse_valid(pat_p);
        for (int k = 0; k < PW / 32; k++) begin
            bus(0, 10'h010 + 10'(4 * k), 0, rd);
            check($sformatf("cap_p%0d", k), rd, pat_p[32*k +: 32]);
        end
        pulse_valid(pat_q);
        bus(0, 10'h010, 0, rd); check("cap_held", rd, pat_p[31:0]);
        bus(0, 10'h004, 0, rd); check("stat_ovf", rd, 32'h3);
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus(1, 10'h004, 32'h1, rd);
        bus(0, 10'h004, 0, rd); check("stat_w1c0", rd, 32'h2);
        pulse_valid(pat_q);
        bus(0, 10'h01C, 0, rd); check("cap_q3", rd, pat_q[127:96]);
        bus(0, 10'h004, 0, rd); check("stat_reload", rd, 32'h3);

        // Sample counter saturation and irq timing (IRQ_EN=0x4)
        repeat (15) pulse_sample();
        bus(0, 10'h008, 0, rd); check("scnt15", rd, 32'd15);
        bus(0, 10'h004, 0, rd); check("stat_pre_sat", rd, 32'h3);
        pulse_sample();
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        step();
        check("irq_rise", {31'd0, irq}, 32'd1);
        repeat (4) pulse_sample();
        bus(0, 10'h008, 0, rd); check("scnt_sat", rd, 32'd15);
        bus(0, 10'h004, 0, rd); check("stat_sat", rd, 32'h7);
        bus(1, 10'h004, 32'h4, rd);
        step();
        check("irq_fall", {31'd0, irq}, 32'd0);
        bus(0, 10'h004, 0, rd); check("stat_after_w1c", rd, 32'h3);

        // Gain shadow / commit, with the last shadow write back-to-back with commit
        bus(1, 10'h200, 32'h1011, rd);
        bus(1, 10'h204, 32'h2022, rd);
        bus(1, 10'h208, 32'h3033, rd);
        check("gain_uncommitted", gain, 32'h0);
        check("bal_uncommitted", bal, 32'h0);
        bus(0, 10'h2FC, 0, rd); check("dirty1", rd, 32'h1);
        bus(0, 10'h204, 0, rd); check("gsh1", rd, 32'h2022);
        bus(1, 10'h20C, 32'h4044, rd);
        bus(1, 10'h2FC, 32'h1, rd);
        check("gain_commit", gain, 32'h44332211);
        check("bal_commit", bal, 32'h40302010);
        bus(0, 10'h2FC, 0, rd); check("dirty0", rd, 32'h0);

        // TX_GO
        bus(1, 10'h108, 32'h1, rd);
        check("go_disabled", {31'd0, tx_valid}, 32'd0);
        check("go_echo", rd, 32'h1);
        bus(1, 10'h100, 32'h80000000, rd);
        bus(1, 10'h108, 32'h1, rd);
        check("go_pulse", {31'd0, tx_valid}, 32'd1);
        step();
        check("go_one_cycle", {31'd0, tx_valid}, 32'd0);
        check("tx_pdata_w0", tx_pdata[31:0], 32'hDEADBEEF);
        check("tx_pdata_w3", tx_pdata[127:96], 32'hCAFEF00D);

        // Counter write vs coincident increment
        tx_drop_incr = 1'b1;
        bus(1, 10'h104, 32'h00050007, rd);
        tx_drop_incr = 1'b0;
        bus(0, 10'h104, 0, rd); check("txcnt_write_wins", rd, 32'h00050007);
        tx_drop_incr = 1'b1; step(); tx_drop_incr = 1'b0;
        bus(0, 10'h104, 0, rd); check("txcnt_incr", rd, 32'h00050008);

        // rx_en=0 ignores capture and samples
        bus(1, 10'h000, 32'h0, rd);
        bus(1, 10'h004, 32'hF, rd);
        bus(1, 10'h008, 32'h3, rd);
        pulse_valid(pat_p);
        pulse_sample();
        bus(0, 10'h004, 0, rd); check("stat_rx_off", rd, 32'h0);
        bus(0, 10'h008, 0, rd); check("scnt_rx_off", rd, 32'h3);
        bus(0, 10'h010, 0, rd); check("cap_rx_off", rd, pat_q[31:0]);

        // Sticky set on the same edge as its W1C
        bus(1, 10'h104, 32'h000F0000, rd);
        tx_retrans_incr = 1'b1;
        bus(1, 10'h004, 32'h8, rd);
        tx_retrans_incr = 1'b0;
        bus(0, 10'h004, 0, rd); check("stat_set_beats_w1c", rd, 32'h8);
        bus(0, 10'h104, 0, rd); check("retr_sat", rd, 32'h000F0000);

        // Reset during an access
        @(negedge clk);
        val = 1'b1; write = 1'b1; addr = 10'h300; wdata = 32'h1; rst = 1'b1;
        step();
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        check("rst_mid_outs", {28'd0, sel, tx_en, rx_en, irq}, 32'd0);
        val = 1'b0; write = 1'b0; addr = '0; wdata = '0; rst = 1'b0;
        step();

        // Randomized counters/status vs model
        m_scnt = 0; m_retr = 0; m_drop = 0; m_stat = 4'd0; m_en = 4'hC;
        bus(1, 10'h00C, 32'(m_en), rd);
        bus(1, 10'h000, 32'h80000000, rd);
        for (int i = 0; i < 400; i++) begin
            int op, w, wr_r, wr_d;
            bit p_s, p_r, p_d, sat_s, sat_t, irq_exp;
            logic [31:0] exp_rd;
            logic [3:0] clr;
            p_s = 1'($urandom_range(0, 1));
            p_r = 1'($urandom_range(0, 1));
            p_d = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 7);
            w = $urandom_range(0, 15);
            wr_r = $urandom_range(0, MAXC);
            wr_d = $urandom_range(0, MAXC);
            rx_sample = p_s; tx_retrans_incr = p_r; tx_drop_incr = p_d;
            exp_rd = 32'h0;
            case (op)
                2: begin bus(0, 10'h004, 0, rd); exp_rd = 32'(m_stat); end
                3: begin bus(0, 10'h008, 0, rd); exp_rd = 32'(m_scnt); end
                4: begin bus(0, 10'h104, 0, rd); exp_rd = (m_retr << 16) | m_drop; end
                5: bus(1, 10'h004, 32'(w), rd);
                6: bus(1, 10'h008, 32'(w), rd);
                7: bus(1, 10'h104, 32'((wr_r << 16) | wr_d), rd);
                default: step();
            endcase
            rx_sample = 1'b0; tx_retrans_incr = 1'b0; tx_drop_incr = 1'b0;
            if (op >= 2 && op <= 4) check($sformatf("rnd_rd%0d_op%0d", i, op), rd, exp_rd);

            sat_s = p_s && (m_scnt == MAXC);
            sat_t = (p_r && (m_retr == MAXC)) || (p_d && (m_drop == MAXC));
            if (op == 6) m_scnt = w;
            else if (p_s && m_scnt < MAXC) m_scnt++;
            if (op == 7) begin
                m_retr = wr_r; m_drop = wr_d;
            end else begin
                if (p_r && m_retr < MAXC) m_retr++;
                if (p_d && m_drop < MAXC) m_drop++;
            end
            clr = (op == 5) ? 4'(w) : 4'd0;
            irq_exp = |(m_stat & m_en);
            m_stat = (m_stat & ~clr) | {sat_t, sat_s, 2'b00};
            check($sformatf("rnd_irq%0d", i), {31'd0, irq}, {31'd0, irq_exp});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_regs_gen2.md
Name: audio_regs_gen2

Overview:
Parametrised second-generation control/status register file for the TDM/packet audio path. It is slave to the single-cycle val/write register bus and drives the TDM2P receiver, P2TDM transmitter, per-channel gain/balance and TDM mux select. Over the first-generation block it adds:
- N-channel gain/balance with a shadow/commit (atomic update) scheme
- payload capture buffering with overflow detection
- saturating counters
- write-1-to-clear sticky status
- a maskable interrupt.

Parameters:
NCH, 4, number of audio channels (1..32); one gain byte and one balance byte per channel
PW, 256, payload width in bits; multiple of 32, 32..1024
CW, 16, counter width (1..16)
AW, 10, bus byte-address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
val  in  1  bus access strobe; each cycle with val=1 is one access
addr  in  AW  byte address; addr[1:0] ignored
write  in  1  1=write, 0=read (qualified by val)
wdata  in  32  write data
rdata  out  32  read data, valid with ready
ready  out  1  access acknowledge, one cycle after val
rx_en  out  1  TDM2P enable
rx_clk_mask  out  8  TDM2P clock mask
rx_clk_patt  out  8  TDM2P clock pattern
rx_sample  in  1  sample-tick pulse
rx_valid  in  1  payload-valid pulse
rx_pdata  in  PW  received payload
tx_en  out  1  P2TDM enable
tx_retrans_incr  in  1  retransmit event pulse
tx_drop_incr  in  1  drop event pulse
tx_valid  out  1  one-cycle transmit strobe
tx_pdata  out  PW  payload to transmit
gain  out  8*NCH  committed gain; channel c at [8c+7:8c]
bal  out  8*NCH  committed balance; same packing
sel  out  1  TDM mux select
irq  out  1  registered level interrupt

Behaviour:
- Reset (sync, rst=1 at clk edge) clears every register and output to 0, including ready, rdata, tx_valid, irq, shadows, capture buffer and dirty flag.
- Bus handshake:
  - val=1 at edge N gives ready=1 at N+1.
  - Reads: rdata holds the addressed value at N+1.
  - Writes: rdata echoes wdata; the register updates at edge N.
  - With val=0, ready=0 and rdata=0.
  - Back-to-back accesses are legal.
- Address map (byte offsets). Unmapped reads return 32'hBADACE55; unmapped writes are ignored.
  - 0x000 RX_CTRL RW: [31] rx_en, [15:8] mask, [7:0] patt.
  - 0x004 STAT, W1C: [0] rx payload valid, [1] rx overflow, [2] sample-count saturated, [3] tx counter saturated.
  - 0x008 RX_SCNT RW: sample count, zero-extended.
  - 0x00C IRQ_EN RW: [3:0].
  - 0x010+4k, k<PW/32, RX_PDATA RO: capture buffer word k.
  - 0x100 TX_CTRL RW: [31] tx_en.
  - 0x104 TX_CNT RW: [31:16] retrans, [15:0] dropped, each CW bits zero-extended; a write loads both.
  - 0x108 TX_GO WO: reads 0.
  - 0x110+4k TX_PDATA RW.
  - 0x200+4c, c<NCH, GAIN_SH RW: [15:8] balance shadow, [7:0] gain shadow.
  - 0x2FC COMMIT: read [0]=dirty.
  - 0x300 SEL RW: [0].
- Capture:
  - rx_valid with rx_en=1 and STAT[0]=0 loads rx_pdata into the buffer and sets STAT[0].
  - If STAT[0]=1, the buffer is held and STAT[1] is set.
  - rx_valid with rx_en=0 is ignored.
- Counters:
  - Sample count increments on rx_sample while rx_en=1.
  - Retrans and dropped counters increment on their pulses regardless of tx_en.
  - All counters saturate at 2^CW-1 and do not wrap.
  - An increment attempted at saturation sets the matching STAT sticky bit.
  - A bus write to a counter on the same edge as an increment: the write wins.
- Sticky bits: a W1C and a set event on the same edge leave the bit set.
- TX_GO: writing wdata[0]=1 with tx_en=1 makes tx_valid=1 for exactly the next cycle; otherwise tx_valid=0.
- Shadow/commit:
  - Writing any GAIN_SH sets dirty.
  - Writing COMMIT with wdata[0]=1 copies all shadows to gain/bal at that edge and clears dirty. gain/bal are visible the cycle after the commit write.
  - A GAIN_SH write and a COMMIT in back-to-back cycles: the commit includes the earlier write.
- irq: registered; irq = |(STAT[3:0] & IRQ_EN[3:0]), so it rises one cycle after the causing STAT bit.
- A reset mid-access drops ready and abandons the access.

Test Plan:
- Reset then read 0x000, 0x2FC, 0x3F0 -> ready one cycle after val; rdata 0, 0, 32'hBADACE55; all outputs 0.
- Write 0x000=0x8000_A55A, then pulse rx_valid with rx_pdata=pattern P, then pulse rx_valid with pattern Q -> rx_en=1, mask 0xA5, patt 0x5A; RX_PDATA words read P; STAT=0x3. Write STAT=0x1, then rx_valid with Q -> buffer=Q, STAT=0x3.
- CW=4: 20 rx_sample pulses with rx_en=1 -> RX_SCNT reads 15 and STAT[2]=1. With IRQ_EN=0x4, irq=1 one cycle after the bit sets; writing STAT=0x4 deasserts irq.
- NCH=4: write GAIN_SH ch0..3 = 0x1011..0x4044 -> gain/bal unchanged and dirty=1. Write COMMIT=1 -> next cycle gain=0x44332211, bal=0x40302010, dirty=0.
- tx_en=0, write TX_GO=1 -> no tx_valid. Set tx_en, write TX_GO=1 -> tx_valid high exactly one cycle.
- Write TX_CNT=0x0005_0007 on the same edge as a tx_drop_incr pulse -> reads 0x0005_0007. A tx_drop_incr the next cycle -> reads 0x0005_0008.
